// File: rtl/monitor_pkg.sv
// Shared types and sizing helpers for the AGC monitor port.
package monitor_pkg;

  localparam int unsigned WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    HOLD    = 2'd2,
    RELEASE = 2'd3
  } inj_state_e;

  // Width of the injector wait counter; never below 1 bit.
  function automatic int unsigned tmo_w(input int unsigned timeout);
    return (timeout < 2) ? 1 : $clog2(timeout);
  endfunction

endpackage

// File: rtl/monitor_fifo.sv
// Synchronous capture FIFO; a push is accepted when full only alongside a pop.
module monitor_fifo
  import monitor_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [WORD_W-1:0] push_data,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [WORD_W-1:0] head_data
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q,  count_d;
  logic              do_push, do_pop;

  assign full      = (count_q == (AW+1)'(DEPTH));
  assign empty     = (count_q == '0);
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign head_data = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/agc_monitor_port.sv
// AGC monitor port: filtered capture of MWL strobes into a FIFO, and a
// gated MDT injector driven by a host handshake.
module agc_monitor_port
  import monitor_pkg::*;
#(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned CNTW    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] MWL,
  input  logic              MONWT,
  input  logic [WORD_W-1:0] cfg_mask,
  input  logic [WORD_W-1:0] cfg_match,
  output logic              cap_valid,
  input  logic              cap_ready,
  output logic [WORD_W-1:0] cap_data,
  output logic              cap_ovf,
  input  logic              ovf_clr,
  output logic [CNTW-1:0]   drop_cnt,
  input  logic              inj_valid,
  output logic              inj_ready,
  input  logic [WORD_W-1:0] inj_data,
  input  logic              MDTGATE,
  output logic [WORD_W-1:0] MDT,
  output logic              inj_done,
  output logic              inj_err
);

  localparam int unsigned TW = tmo_w(TIMEOUT);

  // ---------------- capture path ----------------
  logic              monwt_q;
  logic              rise, hit, push_req, pop, drop;
  logic              full, empty;
  logic [WORD_W-1:0] head_data;
  logic              ovf_q;
  logic [CNTW-1:0]   drop_q;

  assign rise     = MONWT && !monwt_q;
  assign hit      = ((MWL & cfg_mask) == cfg_match);
  assign push_req = rise && hit;
  assign pop      = cap_valid && cap_ready;
  assign drop     = push_req && full && !pop;

  assign cap_valid = !empty;
  assign cap_data  = empty ? '0 : head_data;
  assign cap_ovf   = ovf_q;
  assign drop_cnt  = drop_q;

  monitor_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_req),
    .push_data (MWL),
    .pop       (pop),
    .full      (full),
    .empty     (empty),
    .head_data (head_data)
  );

  // A drop in the same cycle as ovf_clr restarts the count at one.
  always_ff @(posedge clk) begin
    if (rst) begin
      monwt_q <= 1'b0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      monwt_q <= MONWT;
      if (drop) begin
        ovf_q  <= 1'b1;
        if (ovf_clr)            drop_q <= CNTW'(1);
        else if (drop_q != '1)  drop_q <= drop_q + 1'b1;
      end else if (ovf_clr) begin
        ovf_q  <= 1'b0;
        drop_q <= '0;
      end
    end
  end

  // ---------------- inject path ----------------
  inj_state_e        state_q, state_d;
  logic [WORD_W-1:0] word_q,  word_d;
  logic [TW-1:0]     tcnt_q,  tcnt_d;
  logic              done_q,  done_d;
  logic              err_q,   err_d;

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    tcnt_d  = '0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (inj_valid) begin
          word_d  = inj_data;
          state_d = ARMED;
        end
      end
      ARMED: begin
        if (MDTGATE) begin
          state_d = HOLD;
        end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          tcnt_d  = tcnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (!MDTGATE) begin
          state_d = RELEASE;
          done_d  = 1'b1;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      word_q  <= '0;
      tcnt_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      tcnt_q  <= tcnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign inj_ready = (state_q == IDLE);
  assign MDT       = (state_q == ARMED || state_q == HOLD) ? word_q : '0;
  assign inj_done  = done_q;
  assign inj_err   = err_q;

endmodule

// File: tb/tb_agc_monitor_port.sv
// Directed bench for agc_monitor_port: filter table plus capture/inject sequences.
module tb_agc_monitor_port;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] MWL, cfg_mask, cfg_match, inj_data, MDT, cap_data;
  logic        MONWT, cap_valid, cap_ready, cap_ovf, ovf_clr;
  logic [7:0]  drop_cnt;
  logic        inj_valid, inj_ready, MDTGATE, inj_done, inj_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  agc_monitor_port #(.DEPTH(8), .TIMEOUT(16), .CNTW(8)) dut (
    .clk(clk), .rst(rst), .MWL(MWL), .MONWT(MONWT),
    .cfg_mask(cfg_mask), .cfg_match(cfg_match),
    .cap_valid(cap_valid), .cap_ready(cap_ready), .cap_data(cap_data),
    .cap_ovf(cap_ovf), .ovf_clr(ovf_clr), .drop_cnt(drop_cnt),
    .inj_valid(inj_valid), .inj_ready(inj_ready), .inj_data(inj_data),
    .MDTGATE(MDTGATE), .MDT(MDT), .inj_done(inj_done), .inj_err(inj_err)
  );

  typedef struct {
    logic [15:0] mwl;
    logic [15:0] mask;
    logic [15:0] match;
    logic        hit;
  } fvec_t;

  fvec_t tv [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // One MONWT pulse; returns at the negedge just after the sampling edge.
  task automatic strobe(input logic [15:0] w);
    @(negedge clk);
    MWL   = w;
    MONWT = 1'b1;
    @(negedge clk);
    MONWT = 1'b0;
  endtask

  task automatic pop_check(input string nm, input logic [15:0] exp);
    chk({nm, "_valid"}, 32'(cap_valid), 32'd1);
    chk({nm, "_data"},  32'(cap_data),  32'(exp));
    cap_ready = 1'b1;
    @(negedge clk);
    cap_ready = 1'b0;
  endtask

  initial begin
    tv[0] = '{16'h1234, 16'h0000, 16'h0000, 1'b1};
    tv[1] = '{16'h1235, 16'h000F, 16'h0005, 1'b1};
    tv[2] = '{16'h1236, 16'h000F, 16'h0005, 1'b0};
    tv[3] = '{16'hFFF5, 16'h000F, 16'h0005, 1'b1};
    tv[4] = '{16'h8000, 16'h8000, 16'h8000, 1'b1};
    tv[5] = '{16'h7FFF, 16'h8000, 16'h8000, 1'b0};
    tv[6] = '{16'hABCD, 16'hFFFF, 16'hABCD, 1'b1};
    tv[7] = '{16'hABCC, 16'hFFFF, 16'hABCD, 1'b0};

    rst = 1'b1; MWL = '0; MONWT = 1'b0; cfg_mask = '0; cfg_match = '0;
    cap_ready = 1'b0; ovf_clr = 1'b0; inj_valid = 1'b0; inj_data = '0; MDTGATE = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("rst_cap_valid", 32'(cap_valid), 32'd0);
    chk("rst_cap_data",  32'(cap_data),  32'd0);
    chk("rst_cap_ovf",   32'(cap_ovf),   32'd0);
    chk("rst_drop_cnt",  32'(drop_cnt),  32'd0);
    chk("rst_inj_ready", 32'(inj_ready), 32'd1);
    chk("rst_mdt",       32'(MDT),       32'd0);
    chk("rst_inj_done",  32'(inj_done),  32'd0);
    chk("rst_inj_err",   32'(inj_err),   32'd0);

    // Two-cycle strobe captures exactly one word
    @(negedge clk);
    MWL = 16'o37777; MONWT = 1'b1;
    chk("t1_pre_valid", 32'(cap_valid), 32'd0);
    @(negedge clk);
    chk("t1_valid", 32'(cap_valid), 32'd1);
    chk("t1_data",  32'(cap_data),  32'(16'o37777));
    @(negedge clk);
    MONWT = 1'b0; cap_ready = 1'b1;
    @(negedge clk);
    cap_ready = 1'b0;
    chk("t1_after_pop", 32'(cap_valid), 32'd0);

    // Filter table
    for (int unsigned i = 0; i < 8; i++) begin
      @(negedge clk);
      cfg_mask = tv[i].mask; cfg_match = tv[i].match;
      strobe(tv[i].mwl);
      chk($sformatf("flt%0d_valid", i), 32'(cap_valid), 32'(tv[i].hit));
      if (tv[i].hit) begin
        chk($sformatf("flt%0d_data", i), 32'(cap_data), 32'(tv[i].mwl));
        cap_ready = 1'b1;
        @(negedge clk);
        cap_ready = 1'b0;
        chk($sformatf("flt%0d_drained", i), 32'(cap_valid), 32'd0);
      end
    end

    // Filter ordering
    cfg_mask = 16'h000F; cfg_match = 16'h0005;
    strobe(16'h1235); strobe(16'h1236); strobe(16'hFFF5);
    pop_check("ord0", 16'h1235);
    pop_check("ord1", 16'hFFF5);
    chk("ord_empty", 32'(cap_valid), 32'd0);

    // Overflow, clear, full push+pop, drop-wins-over-clear
    cfg_mask = '0; cfg_match = '0;
    for (int unsigned i = 0; i < 10; i++) strobe(16'h0100 + 16'(i));
    chk("ovf_flag", 32'(cap_ovf),  32'd1);
    chk("ovf_cnt",  32'(drop_cnt), 32'd2);
    @(negedge clk); ovf_clr = 1'b1;
    @(negedge clk); ovf_clr = 1'b0;
    chk("clr_flag",  32'(cap_ovf),   32'd0);
    chk("clr_cnt",   32'(drop_cnt),  32'd0);
    chk("clr_valid", 32'(cap_valid), 32'd1);
    chk("clr_head",  32'(cap_data),  32'h0100);
    @(negedge clk);
    MWL = 16'h0200; MONWT = 1'b1; cap_ready = 1'b1;
    @(negedge clk);
    MONWT = 1'b0; cap_ready = 1'b0;
    chk("pp_flag", 32'(cap_ovf),  32'd0);
    chk("pp_cnt",  32'(drop_cnt), 32'd0);
    @(negedge clk);
    MWL = 16'h0300; MONWT = 1'b1; ovf_clr = 1'b1;
    @(negedge clk);
    MONWT = 1'b0; ovf_clr = 1'b0;
    chk("dw_flag", 32'(cap_ovf),  32'd1);
    chk("dw_cnt",  32'(drop_cnt), 32'd1);
    for (int unsigned i = 1; i < 8; i++) pop_check($sformatf("drain%0d", i), 16'h0100 + 16'(i));
    pop_check("drain_pp", 16'h0200);
    chk("drain_empty", 32'(cap_valid), 32'd0);

    // Drop counter saturation
    for (int unsigned i = 0; i < 8 + 300; i++) strobe(16'(i));
    chk("sat_cnt",  32'(drop_cnt), 32'hFF);
    chk("sat_flag", 32'(cap_ovf),  32'd1);
    @(negedge clk); ovf_clr = 1'b1; cap_ready = 1'b1;
    repeat (8) @(negedge clk);
    ovf_clr = 1'b0; cap_ready = 1'b0;
    chk("sat_clr_cnt", 32'(drop_cnt),  32'd0);
    chk("sat_drained", 32'(cap_valid), 32'd0);

    // Injection with 3-cycle gate
    @(negedge clk);
    inj_valid = 1'b1; inj_data = 16'hA5A5;
    @(negedge clk);
    inj_valid = 1'b0;
    chk("inj_armed_mdt",   32'(MDT),       32'hA5A5);
    chk("inj_armed_ready", 32'(inj_ready), 32'd0);
    MDTGATE = 1'b1;
    repeat (3) @(negedge clk);
    chk("inj_hold_mdt", 32'(MDT), 32'hA5A5);
    MDTGATE = 1'b0;
    @(negedge clk);
    chk("inj_rel_mdt",  32'(MDT),      32'd0);
    chk("inj_rel_done", 32'(inj_done), 32'd1);
    @(negedge clk);
    chk("inj_done_once", 32'(inj_done),  32'd0);
    chk("inj_idle_ready", 32'(inj_ready), 32'd1);

    // Timeout abort after 16 ARMED cycles
    begin
      int early_err = 0;
      int bad_mdt   = 0;
      int any_done  = 0;
      @(negedge clk);
      inj_valid = 1'b1; inj_data = 16'h0001;
      for (int k = 1; k <= 16; k++) begin
        @(negedge clk);
        inj_valid = 1'b0;
        if (inj_err) early_err++;
        if (inj_done) any_done++;
        if (MDT !== 16'h0001) bad_mdt++;
      end
      chk("to_early_err", 32'(early_err), 32'd0);
      chk("to_armed_mdt", 32'(bad_mdt),   32'd0);
      @(negedge clk);
      if (inj_done) any_done++;
      chk("to_err",   32'(inj_err),   32'd1);
      chk("to_mdt",   32'(MDT),       32'd0);
      chk("to_ready", 32'(inj_ready), 32'd1);
      @(negedge clk);
      if (inj_done) any_done++;
      chk("to_err_once", 32'(inj_err),  32'd0);
      chk("to_no_done",  32'(any_done), 32'd0);
    end

    // Gate already high at arm; gate re-rise during RELEASE ignored
    @(negedge clk);
    inj_valid = 1'b1; inj_data = 16'h3C3C; MDTGATE = 1'b1;
    @(negedge clk);
    inj_valid = 1'b0;
    chk("pg_mdt", 32'(MDT), 32'h3C3C);
    @(negedge clk);
    MDTGATE = 1'b0;
    chk("pg_hold_mdt",  32'(MDT),      32'h3C3C);
    chk("pg_hold_done", 32'(inj_done), 32'd0);
    @(negedge clk);
    chk("pg_done", 32'(inj_done), 32'd1);
    MDTGATE = 1'b1;
    @(negedge clk);
    MDTGATE = 1'b0;
    chk("pg_idle_ready", 32'(inj_ready), 32'd1);
    chk("pg_idle_mdt",   32'(MDT),       32'd0);
    @(negedge clk);
    chk("pg_stay_idle", 32'(MDT), 32'd0);

    // Reset while in HOLD with a captured word pending
    strobe(16'h4444);
    @(negedge clk);
    inj_valid = 1'b1; inj_data = 16'h5A5A; MDTGATE = 1'b1;
    @(negedge clk);
    inj_valid = 1'b0;
    @(negedge clk);
    chk("rh_hold_mdt", 32'(MDT), 32'h5A5A);
    rst = 1'b1;
    @(negedge clk);
    chk("rh_mdt",   32'(MDT),       32'd0);
    chk("rh_ready", 32'(inj_ready), 32'd1);
    chk("rh_done",  32'(inj_done),  32'd0);
    chk("rh_err",   32'(inj_err),   32'd0);
    chk("rh_fifo",  32'(cap_valid), 32'd0);
    rst = 1'b0; MDTGATE = 1'b0;
    @(negedge clk);
    chk("rh_no_done", 32'(inj_done), 32'd0);
    chk("rh_no_err",  32'(inj_err),  32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/agc_monitor_port.md
Name: agc_monitor_port

Overview:
- Test-equipment side of the AGC monitor interface.
- Capture path: observes the 16-bit monitor write lines (MWL01..MWL16) that the arithmetic slices drive, filters each word and buffers it for the host.
- Inject path: drives the monitor data transfer lines (MDT01..MDT16) that the slices gate onto the write bus, using a host handshake and an AGC-supplied gate window.
- Sits between the logic-module chain and the simulation/GSE host.

Parameters:
- DEPTH, 8, capture FIFO depth in words; power of 2, minimum 2.
- TIMEOUT, 1024, clk cycles an armed injection waits for MDTGATE before aborting.
- CNTW, 8, width of the saturating drop counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- MWL  in  16  monitor write lines, bit 0 = MWL01.
- MONWT  in  1  AGC strobe; MWL is valid while high.
- cfg_mask  in  16  capture filter mask.
- cfg_match  in  16  capture filter value.
- cap_valid  out  1  capture word available.
- cap_ready  in  1  host accepts capture word.
- cap_data  out  16  head-of-FIFO word.
- cap_ovf  out  1  sticky overflow flag.
- ovf_clr  in  1  clears cap_ovf and drop_cnt.
- drop_cnt  out  CNTW  saturating count of dropped words.
- inj_valid  in  1  host offers injection word.
- inj_ready  out  1  injector idle.
- inj_data  in  16  word to inject.
- MDTGATE  in  1  AGC window in which MDT is read onto the write bus.
- MDT  out  16  monitor data transfer lines, bit 0 = MDT01.
- inj_done  out  1  one-cycle pulse on successful injection.
- inj_err  out  1  one-cycle pulse on timeout abort.

Behaviour:
- Reset values: cap_valid=0, cap_data=0, cap_ovf=0, drop_cnt=0, inj_ready=1, MDT=0, inj_done=0, inj_err=0. FIFO is emptied. Injector state = IDLE.
- Reset mid-injection: MDT is forced to 0 on the next edge. No done or err pulse is issued.
- Capture, edge detection: MONWT is registered. A rising edge (prev=0, cur=1) samples the MWL value present in that same cycle.
- Capture, filter: the word is pushed only if (MWL & cfg_mask) == cfg_match. A mask of 0 captures every strobe.
- Capture, latency: cap_valid rises 1 cycle after the push edge when the FIFO was empty. cap_data is valid whenever cap_valid=1.
- Pop occurs when cap_valid && cap_ready. The next word appears on the following cycle.
- Simultaneous push and pop on a full FIFO: both succeed and nothing is dropped.
- Push when full with no pop: the new word is discarded, cap_ovf is set, and drop_cnt increments, saturating at all-ones.
- Push when empty with cap_ready held high: the word is still presented for at least 1 cycle.
- ovf_clr clears cap_ovf and drop_cnt. If ovf_clr and a drop occur in the same cycle, the drop wins: cap_ovf=1, drop_cnt=1.
- Injector states:
  - IDLE: inj_ready=1, MDT=0. When inj_valid is high, latch inj_data and go to ARMED.
  - ARMED: MDT = latched word, wait counter runs. On MDTGATE high, go to HOLD. When the counter reaches TIMEOUT-1, go to IDLE with MDT=0 and pulse inj_err.
  - HOLD: MDT held. When MDTGATE falls, go to RELEASE.
  - RELEASE: MDT=0, pulse inj_done, go to IDLE.
- MDTGATE already high when the injector arms: counts as the gate, so the next cycle enters HOLD.
- A gate that falls and rises again while in RELEASE is ignored.
- The capture and inject paths are fully independent. An injected word echoed back on MWL is captured normally.

Decomposition:
- Shared package monitor_pkg holds:
  - WORD_W = 16
  - injector state enum {IDLE, ARMED, HOLD, RELEASE}
  - timeout counter width, derived as clog2(TIMEOUT)
- Sub-module monitor_fifo: synchronous FIFO, parameter DEPTH. Ports: push, push_data, pop, full, empty, head_data.
- The filter, drop counter and injector FSM live in the top module.

Test Plan:
- After reset, pulse MONWT for 2 cycles with MWL=16'o37777 and mask=0 -> exactly one word; cap_valid at the +1 cycle, cap_data=16'o37777; pop leaves cap_valid=0.
- Set mask=16'h000F and match=16'h0005, then strobe MWL=16'h1235, 16'h1236, 16'hFFF5 with cap_ready=0 -> FIFO holds 16'h1235 then 16'hFFF5, in that order.
- With cap_ready=0, issue 10 strobes with DEPTH=8 -> 8 words kept, cap_ovf=1, drop_cnt=2. Then assert ovf_clr -> cap_ovf=0, drop_cnt=0, FIFO contents unchanged.
- Offer inj_data=16'hA5A5 -> MDT=16'hA5A5 in ARMED. Raise MDTGATE for 3 cycles, then lower it -> MDT=0 and a 1-cycle inj_done one cycle after the fall; inj_ready=1 after that.
- Offer inj_data=16'h0001 with MDTGATE held low, TIMEOUT=16 -> inj_err pulse after 16 cycles in ARMED, MDT=0, no inj_done.
- Assert rst while in HOLD -> MDT=0 and inj_ready=1 on the next edge, no pulses, FIFO empty.
